gpr_wb_arbiter: RTL and testbench

//  Shares the single GPRs write port between the ALU and load-unit writeback paths.

---
 rtl/gpr_wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Shares the single GPR write port between the ALU and load-unit writeback
//   paths. Round-robin arbitration with valid/ready handshakes feeds a
//   registered write stage. A per-register pending-write scoreboard is
//   incremented by issue-stage claims and decremented by retiring writes. It
//   drives busy[] for the decoder's RAW stall.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_dest/alu_data   ALU writeback handshake + payload
//   mem_valid/mem_ready/mem_dest/mem_data   load writeback handshake + payload
//   claim_en, claim_dest            issue stage reserves a destination
//   busy                            bit r set while register r has pending writes
//   reg_write_en/_dest/_data        GPR write port
//   claim_err                       pulse: claim dropped on a saturated counter
//   wb_err                          pulse: write to a register with nothing pending
//   contention_cnt                  saturating count of cycles with both valid
module gpr_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PEND_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_dest,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_dest,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        reg_write_dest,
  output logic [DATA_W-1:0]        reg_write_data,
  output logic                     claim_err,
  output logic                     wb_err,
  output logic [CNT_W-1:0]         contention_cnt
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  grant_t last_grant;
  grant_t last_grant_next;

  logic grant_alu;
  logic grant_mem;
  logic wr_en_q;

  logic [PEND_W-1:0] pend      [NREG];
  logic [PEND_W-1:0] pend_next [NREG];
  logic [NREG-1:0]   claim_vec;
  logic [NREG-1:0]   retire_vec;
  logic              claim_sat;

  // Last-grant register; reset to MEM so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_MEM;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Grant ownership only moves on an actual handshake.
  always_comb begin
    last_grant_next = last_grant;
    if (grant_alu) begin
      last_grant_next = GRANT_ALU;
    end else if (grant_mem) begin
      last_grant_next = GRANT_MEM;
    end
  end

  // Combinational grant: on a tie the requester that did not win last time wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        if (last_grant == GRANT_MEM) begin
          grant_alu = 1'b1;
        end else begin
          grant_mem = 1'b1;
        end
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Write stage: the accepted payload is presented to the GPRs one cycle later.
  // Dest/data hold their last value when nothing was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q        <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else begin
      wr_en_q <= grant_alu | grant_mem;
      if (grant_alu) begin
        reg_write_dest <= alu_dest;
        reg_write_data <= alu_data;
      end else if (grant_mem) begin
        reg_write_dest <= mem_dest;
        reg_write_data <= mem_data;
      end
    end
  end

  // A write accepted just before reset is dropped rather than reaching the GPRs.
  assign reg_write_en = wr_en_q & ~rst;

  assign claim_vec  = claim_en     ? (NREG'(1) << claim_dest)     : '0;
  assign retire_vec = reg_write_en ? (NREG'(1) << reg_write_dest) : '0;

  // A claim and a retire on the same register cancel out with no error.
  assign wb_err    = reg_write_en && !claim_vec[reg_write_dest] &&
                     (pend[reg_write_dest] == '0);
  assign claim_sat = claim_en && !retire_vec[claim_dest] &&
                     (pend[claim_dest] == PEND_MAX);

  // Saturating pending counters; out-of-range updates leave the count alone.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_next[r] = pend[r];
      if (claim_vec[r] && !retire_vec[r]) begin
        if (pend[r] != PEND_MAX) begin
          pend_next[r] = pend[r] + PEND_W'(1);
        end
      end else if (retire_vec[r] && !claim_vec[r]) begin
        if (pend[r] != '0) begin
          pend_next[r] = pend[r] - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
      claim_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= pend_next[r];
      end
      claim_err <= claim_sat;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (pend[r] != '0);
    end
  end

  // Contention statistic: cycles where both paths want the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention_cnt <= '0;
    end else if (alu_valid && mem_valid && contention_cnt != CNT_MAX) begin
      contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter
//   Self-checking bench for gpr_wb_arbiter. Directed scenarios check fixed
//   expected values. A randomized run is compared against a behavioural
//   model that tracks pending counts per register, the pending write and
//   the round-robin owner.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;
  logic        claim_en;
  logic [2:0]  claim_dest;
  logic [7:0]  busy;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic        claim_err;
  logic        wb_err;
  logic [7:0]  contention_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_pend [8];
  bit          m_last_alu;
  bit          m_wen;
  logic [2:0]  m_wdest;
  logic [15:0] m_wdata;
  bit          m_claim_err;
  int          m_cnt;

  always #5 clk = ~clk;

  gpr_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .claim_en(claim_en), .claim_dest(claim_dest), .busy(busy),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .claim_err(claim_err), .wb_err(wb_err), .contention_cnt(contention_cnt)
  );

  // Round robin: on a tie the side that did not win last time is served.
  function automatic bit exp_alu_ready();
    return !rst && alu_valid && (!mem_valid || !m_last_alu);
  endfunction

  function automatic bit exp_mem_ready();
    return !rst && mem_valid && (!alu_valid || m_last_alu);
  endfunction

  function automatic bit exp_wen();
    return m_wen && !rst;
  endfunction

  function automatic bit exp_wb_err();
    return exp_wen() && m_pend[m_wdest] == 0 && !(claim_en && claim_dest == m_wdest);
  endfunction

  function automatic logic [7:0] exp_busy();
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (m_pend[r] != 0);
    return b;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    bit ga, gm, wen_now, same;
    if (rst) begin
      for (int r = 0; r < 8; r++) m_pend[r] = 0;
      m_last_alu = 0; m_wen = 0; m_wdest = '0; m_wdata = '0;
      m_claim_err = 0; m_cnt = 0;
    end else begin
      ga = exp_alu_ready();
      gm = exp_mem_ready();
      wen_now = exp_wen();
      same = claim_en && wen_now && claim_dest == m_wdest;
      m_claim_err = 0;
      if (!same) begin
        if (claim_en) begin
          if (m_pend[claim_dest] == 3) m_claim_err = 1;
          else m_pend[claim_dest]++;
        end
        if (wen_now && m_pend[m_wdest] > 0) m_pend[m_wdest]--;
      end
      if (alu_valid && mem_valid && m_cnt < 255) m_cnt++;
      if (ga) begin
        m_wen = 1; m_wdest = alu_dest; m_wdata = alu_data; m_last_alu = 1;
      end else if (gm) begin
        m_wen = 1; m_wdest = mem_dest; m_wdata = mem_data; m_last_alu = 0;
      end else begin
        m_wen = 0;
      end
    end
  endtask

  // One clock: update the model, pass the rising edge, return at the falling edge.
  task automatic cycle();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_dest = '0; alu_data = '0;
    mem_valid = 0; mem_dest = '0; mem_data = '0;
    claim_en = 0; claim_dest = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  function automatic logic [2:0] rand_dest();
    if ($urandom_range(0, 1) == 0) return 3'($urandom_range(0, 3));
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cycle();
    alu_valid = 1; mem_valid = 1; claim_en = 1; claim_dest = 3'd1;
    cycle();
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %0b expected 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %0b expected 0", mem_ready); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", reg_write_en); end
    checks++; if (reg_write_dest !== 3'd0 || reg_write_data !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %0h/%0h expected 0/0", reg_write_dest, reg_write_data); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (contention_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", contention_cnt); end
    checks++; if (claim_err !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %0b/%0b expected 0/0", claim_err, wb_err); end
    idle_inputs();
    rst = 0;
    cycle();
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_dest = 3'd3; alu_data = 16'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got %0b/%0b expected 1/0", alu_ready, mem_ready); end
    cycle();
    alu_valid = 0;
    #1;
    checks++; if (reg_write_en !== 1'b1) begin errors++; $display("FAIL single_wen: got %0b expected 1", reg_write_en); end
    checks++; if (reg_write_dest !== 3'd3 || reg_write_data !== 16'h1234) begin errors++; $display("FAIL single_payload: got %0h/%0h expected 3/1234", reg_write_dest, reg_write_data); end
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL single_wb_err: got %0b expected 1", wb_err); end
    cycle();
    #1;
    checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd3 || reg_write_data !== 16'h1234) begin errors++; $display("FAIL single_hold: got %0b/%0h/%0h expected 0/3/1234", reg_write_en, reg_write_dest, reg_write_data); end
  endtask

  task automatic test_contention();
    bit alu_turn;
    do_reset();
    alu_valid = 1; alu_dest = 3'd1; alu_data = 16'hAAAA;
    mem_valid = 1; mem_dest = 3'd2; mem_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      alu_turn = (i % 2 == 0);
      #1;
      checks++; if (alu_ready !== alu_turn || mem_ready !== !alu_turn) begin errors++; $display("FAIL tie_grant%0d: got %0b/%0b expected %0b/%0b", i, alu_ready, mem_ready, alu_turn, !alu_turn); end
      if (i > 0) begin
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== (alu_turn ? 3'd2 : 3'd1)) begin errors++; $display("FAIL tie_write%0d: got %0b/%0h expected 1/%0h", i, reg_write_en, reg_write_dest, alu_turn ? 3'd2 : 3'd1); end
      end
      cycle();
    end
    idle_inputs();
    #1;
    checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd2 || reg_write_data !== 16'h5555) begin errors++; $display("FAIL tie_last_write: got %0b/%0h/%0h expected 1/2/5555", reg_write_en, reg_write_dest, reg_write_data); end
    checks++; if (contention_cnt !== 8'd4) begin errors++; $display("FAIL tie_cnt: got %0d expected 4", contention_cnt); end
    cycle();
  endtask

  task automatic test_contention_saturate();
    do_reset();
    alu_valid = 1; alu_dest = 3'd0; alu_data = 16'h0001;
    mem_valid = 1; mem_dest = 3'd7; mem_data = 16'h0002;
    repeat (255) cycle();
    #1;
    checks++; if (contention_cnt !== 8'd255) begin errors++; $display("FAIL cnt_reach_max: got %0d expected 255", contention_cnt); end
    repeat (5) cycle();
    #1;
    checks++; if (contention_cnt !== 8'd255) begin errors++; $display("FAIL cnt_saturate: got %0d expected 255", contention_cnt); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_claim_saturate();
    do_reset();
    claim_en = 1; claim_dest = 3'd5;
    repeat (3) cycle();
    claim_en = 0;
    #1;
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL sat_busy: got %0h expected 20", busy); end
    checks++; if (claim_err !== 1'b0) begin errors++; $display("FAIL sat_no_err: got %0b expected 0", claim_err); end
    claim_en = 1;
    cycle();
    claim_en = 0;
    #1;
    checks++; if (claim_err !== 1'b1) begin errors++; $display("FAIL sat_claim_err: got %0b expected 1", claim_err); end
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL sat_busy_after: got %0h expected 20", busy); end
    alu_valid = 1; alu_dest = 3'd5;
    for (int k = 0; k < 3; k++) begin
      alu_data = 16'(16'h0500 + k);
      #1;
      if (k > 0) begin
        checks++; if (reg_write_en !== 1'b1 || wb_err !== 1'b0 || busy !== 8'h20) begin errors++; $display("FAIL sat_retire%0d: got %0b/%0b/%0h expected 1/0/20", k, reg_write_en, wb_err, busy); end
      end
      cycle();
    end
    alu_valid = 0;
    #1;
    checks++; if (reg_write_en !== 1'b1 || wb_err !== 1'b0 || busy !== 8'h20 || claim_err !== 1'b0) begin errors++; $display("FAIL sat_retire_last: got %0b/%0b/%0h/%0b expected 1/0/20/0", reg_write_en, wb_err, busy, claim_err); end
    cycle();
    #1;
    checks++; if (busy !== 8'h00 || reg_write_en !== 1'b0) begin errors++; $display("FAIL sat_drained: got %0h/%0b expected 0/0", busy, reg_write_en); end
  endtask

  task automatic test_wb_err();
    do_reset();
    mem_valid = 1; mem_dest = 3'd6; mem_data = 16'hBEEF;
    cycle();
    mem_valid = 0;
    #1;
    checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd6 || wb_err !== 1'b1) begin errors++; $display("FAIL wberr_pulse: got %0b/%0h/%0b expected 1/6/1", reg_write_en, reg_write_dest, wb_err); end
    cycle();
    #1;
    checks++; if (busy !== 8'h00 || wb_err !== 1'b0) begin errors++; $display("FAIL wberr_after: got %0h/%0b expected 0/0", busy, wb_err); end
  endtask

  task automatic test_claim_retire_same();
    do_reset();
    claim_en = 1; claim_dest = 3'd4;
    cycle();
    claim_en = 0;
    alu_valid = 1; alu_dest = 3'd4; alu_data = 16'h4444;
    cycle();
    alu_valid = 0;
    claim_en = 1; claim_dest = 3'd4;
    #1;
    checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd4 || wb_err !== 1'b0) begin errors++; $display("FAIL same_write: got %0b/%0h/%0b expected 1/4/0", reg_write_en, reg_write_dest, wb_err); end
    cycle();
    claim_en = 0;
    #1;
    checks++; if (busy !== 8'h10 || claim_err !== 1'b0) begin errors++; $display("FAIL same_net_zero: got %0h/%0b expected 10/0", busy, claim_err); end
    alu_valid = 1;
    cycle();
    alu_valid = 0;
    #1;
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL same_final_retire: got %0b expected 0", wb_err); end
    cycle();
    #1;
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL same_drained: got %0h expected 0", busy); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    claim_en = 1; claim_dest = 3'd2;
    alu_valid = 1; alu_dest = 3'd2; alu_data = 16'h2222;
    cycle();
    claim_en = 0;
    rst = 1;
    mem_valid = 1; mem_dest = 3'd7; mem_data = 16'h7777;
    #1;
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %0b/%0b expected 0/0", alu_ready, mem_ready); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %0b expected 0", reg_write_en); end
    cycle();
    #1;
    checks++; if (reg_write_en !== 1'b0 || busy !== 8'h00) begin errors++; $display("FAIL midrst_after: got %0b/%0h expected 0/0", reg_write_en, busy); end
    rst = 0;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_first_tie: got %0b/%0b expected 1/0", alu_ready, mem_ready); end
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    bit hs_a, hs_m;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid && $urandom_range(0, 1) == 1) begin
        alu_valid = 1; alu_dest = rand_dest(); alu_data = 16'($urandom);
      end
      if (!mem_valid && $urandom_range(0, 1) == 1) begin
        mem_valid = 1; mem_dest = rand_dest(); mem_data = 16'($urandom);
      end
      claim_en = ($urandom_range(0, 2) == 0);
      claim_dest = rand_dest();
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if (alu_ready !== exp_alu_ready() || mem_ready !== exp_mem_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %0b/%0b expected %0b/%0b", i, alu_ready, mem_ready, exp_alu_ready(), exp_mem_ready()); end
      checks++; if (alu_ready === 1'b1 && mem_ready === 1'b1) begin errors++; $display("FAIL rnd_two_ready@%0d: got 1/1 expected at most one", i); end
      checks++; if (reg_write_en !== exp_wen()) begin errors++; $display("FAIL rnd_wen@%0d: got %0b expected %0b", i, reg_write_en, exp_wen()); end
      if (exp_wen()) begin
        checks++; if (reg_write_dest !== m_wdest || reg_write_data !== m_wdata) begin errors++; $display("FAIL rnd_payload@%0d: got %0h/%0h expected %0h/%0h", i, reg_write_dest, reg_write_data, m_wdest, m_wdata); end
      end
      checks++; if (wb_err !== exp_wb_err()) begin errors++; $display("FAIL rnd_wb_err@%0d: got %0b expected %0b", i, wb_err, exp_wb_err()); end
      checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy@%0d: got %0h expected %0h", i, busy, exp_busy()); end
      checks++; if (claim_err !== m_claim_err) begin errors++; $display("FAIL rnd_claim_err@%0d: got %0b expected %0b", i, claim_err, m_claim_err); end
      checks++; if (contention_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", i, contention_cnt, m_cnt); end
      hs_a = alu_valid && exp_alu_ready();
      hs_m = mem_valid && exp_mem_ready();
      cycle();
      if (hs_a) alu_valid = 0;
      if (hs_m) mem_valid = 0;
    end
    rst = 0;
    idle_inputs();
    cycle();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_alu();
    test_contention();
    test_contention_saturate();
    test_claim_saturate();
    test_wb_err();
    test_claim_retire_same();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
